// File: rtl/keypad_matrix_scanner_if.sv
// Key event bus from the keypad scanner to the frequency-entry logic.
// master: the scanner driving key_code/key_valid/key_held; slave: the consumer.
interface keypad_matrix_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (output key_code, output key_valid, output key_held);
    modport slave  (input  key_code, input  key_valid, input  key_held);
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner with press/release debounce and a one-clk key strobe.
// Optional auto-repeat while a key stays pressed: define KEYPAD_SCAN_REPEAT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// SCAN     | walking rows one per scan tick, waiting for any low column
// DEBOUNCE | row frozen, counting ticks with the captured column pattern
// PRESSED  | key accepted and strobed, waiting for all columns high
// RELEASE  | all columns high, counting ticks before declaring release
module keypad_matrix_scanner #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    scan_q,
    input  logic [3:0]              cols,
    output logic [3:0]              rows,
    keypad_matrix_scanner_if.master key
);

    localparam int CNT_MAX = (DEBOUNCE_TICKS > REPEAT_TICKS) ? DEBOUNCE_TICKS : REPEAT_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;

    state_t             state, state_n;
    logic [3:0]         cols_m, cols_s;
    logic               scan_q_d;
    logic               tick;
    logic [1:0]         row_idx, row_idx_n;
    logic [1:0]         col_idx;
    logic [3:0]         cap_cols, cap_cols_n;
    logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
    logic [3:0]         code_n;
    logic               valid_n, held_n;
`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
    logic [RPT_W-1:0]   rpt, rpt_n, rpt_inc;
`endif

    // scan_q history keeps updating while disabled, so re-enabling never fakes an edge
    assign tick    = scan_q & ~scan_q_d & ena;
    assign cnt_inc = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + 1'b1;
`ifdef KEYPAD_SCAN_REPEAT_EN
    assign rpt_inc = (rpt == RPT_W'(REPEAT_TICKS)) ? rpt : rpt + 1'b1;
`endif

    always_comb begin
        col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols_s[i]) col_idx = 2'(i);
        end
    end

    always_comb begin
        state_n    = state;
        row_idx_n  = row_idx;
        cap_cols_n = cap_cols;
        cnt_n      = cnt;
        code_n     = key.key_code;
        held_n     = key.key_held;
        valid_n    = 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
        rpt_n      = rpt;
`endif
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (cols_s == 4'hF) begin
                        row_idx_n = row_idx + 2'd1;
                    end else begin
                        cap_cols_n = cols_s;
                        if (DEBOUNCE_TICKS == 1) begin
                            code_n  = {row_idx, col_idx};
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            cnt_n   = '0;
                            state_n = ST_PRESSED;
                        end else begin
                            cnt_n   = CNT_W'(1);
                            state_n = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (cols_s == cap_cols) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= CNT_W'(DEBOUNCE_TICKS)) begin
                            code_n  = {row_idx, col_idx};
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            cnt_n   = '0;
                            state_n = ST_PRESSED;
                        end
                    end else begin
                        cnt_n     = '0;
                        row_idx_n = row_idx + 2'd1;
                        state_n   = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    if (cols_s == 4'hF) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            held_n    = 1'b0;
                            cnt_n     = '0;
                            row_idx_n = row_idx + 2'd1;
                            state_n   = ST_SCAN;
                        end else begin
                            cnt_n   = CNT_W'(1);
                            state_n = ST_RELEASE;
                        end
                    end else begin
`ifdef KEYPAD_SCAN_REPEAT_EN
                        rpt_n = rpt_inc;
                        if (rpt_inc >= RPT_W'(REPEAT_TICKS)) begin
                            valid_n = 1'b1;
                            rpt_n   = '0;
                        end
`endif
                    end
                end
                ST_RELEASE: begin
                    if (cols_s == 4'hF) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= CNT_W'(DEBOUNCE_TICKS)) begin
                            held_n    = 1'b0;
                            cnt_n     = '0;
                            row_idx_n = row_idx + 2'd1;
                            state_n   = ST_SCAN;
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = ST_PRESSED;
                    end
                end
                default: state_n = ST_SCAN;
            endcase
        end
`ifdef KEYPAD_SCAN_REPEAT_EN
        if (state_n != ST_PRESSED) rpt_n = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cols_m        <= 4'hF;
            cols_s        <= 4'hF;
            scan_q_d      <= 1'b0;
            state         <= ST_SCAN;
            row_idx       <= 2'd0;
            rows          <= 4'b1110;
            cap_cols      <= 4'hF;
            cnt           <= '0;
            key.key_code  <= 4'd0;
            key.key_valid <= 1'b0;
            key.key_held  <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
            rpt           <= '0;
`endif
        end else begin
            cols_m        <= cols;
            cols_s        <= cols_m;
            scan_q_d      <= scan_q;
            state         <= state_n;
            row_idx       <= row_idx_n;
            rows          <= ~(4'b0001 << row_idx_n);
            cap_cols      <= cap_cols_n;
            cnt           <= cnt_n;
            key.key_code  <= code_n;
            key.key_valid <= valid_n;
            key.key_held  <= held_n;
`ifdef KEYPAD_SCAN_REPEAT_EN
            rpt           <= rpt_n;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a keypad model closes switches onto the
// driven rows; a tick-level reference model predicts rows and key events.
module tb_keypad_matrix_scanner;
    localparam int DEB = 4;
    localparam int RPT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        scan_q = 1'b0;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [15:0] mask = 16'h0;

    int checks = 0;
    int errors = 0;
    int n_strobes = 0;

    keypad_matrix_scanner_if kif();

    keypad_matrix_scanner #(.DEBOUNCE_TICKS(DEB), .REPEAT_TICKS(RPT)) dut (
        .clk(clk), .rst(rst), .ena(ena), .scan_q(scan_q),
        .cols(cols), .rows(rows), .key(kif)
    );

    always #5 clk = ~clk;

    // physical keypad: a closed switch pulls its column low when its row is driven low
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            if (rows[r] == 1'b0)
                for (int c = 0; c < 4; c++)
                    if (mask[r*4+c]) cols[c] = 1'b0;
    end

    always @(negedge clk) if (kif.key_valid === 1'b1) n_strobes++;

    // reference model, advanced once per enabled scan tick
    int         m_row, m_stable, m_rel, m_rpt, m_strobes;
    bit         m_cand, m_held, m_valid;
    logic [3:0] m_cap, m_code;

    function automatic logic [3:0] row_pat(int r);
        logic [3:0] p;
        p = 4'hF;
        p[r[1:0]] = 1'b0;
        return p;
    endfunction

    function automatic int low_idx(logic [3:0] c);
        for (int i = 0; i < 4; i++) if (!c[i]) return i;
        return 0;
    endfunction

    function automatic logic [3:0] model_cols();
        logic [3:0] c;
        c = 4'hF;
        for (int i = 0; i < 4; i++) if (mask[m_row*4+i]) c[i] = 1'b0;
        return c;
    endfunction

    task automatic model_reset();
        m_row = 0; m_stable = 0; m_rel = 0; m_rpt = 0;
        m_cand = 0; m_held = 0; m_valid = 0;
        m_cap = 4'hF; m_code = 4'h0;
    endtask

    task automatic accept(logic [3:0] c);
        m_code = 4'(m_row*4 + low_idx(c));
        m_held = 1; m_cand = 0; m_rel = 0; m_rpt = 0;
        m_valid = 1; m_strobes++;
    endtask

    task automatic model_tick();
        logic [3:0] c;
        c = model_cols();
        m_valid = 0;
        if (!m_held) begin
            if (!m_cand) begin
                if (c == 4'hF) m_row = (m_row + 1) % 4;
                else begin
                    m_cand = 1; m_cap = c; m_stable = 1;
                    if (m_stable >= DEB) accept(c);
                end
            end else if (c == m_cap) begin
                m_stable++;
                if (m_stable >= DEB) accept(c);
            end else begin
                m_cand = 0; m_row = (m_row + 1) % 4;
            end
        end else if (c == 4'hF) begin
            m_rel++; m_rpt = 0;
            if (m_rel >= DEB) begin
                m_held = 0; m_rel = 0; m_row = (m_row + 1) % 4;
            end
        end else if (m_rel > 0) begin
            m_rel = 0; m_rpt = 0;
        end else begin
`ifdef KEYPAD_SCAN_REPEAT_EN
            m_rpt++;
            if (m_rpt >= RPT) begin
                m_rpt = 0; m_valid = 1; m_strobes++;
            end
`endif
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one scan_q period of 8 clocks; the tick lands on the 4th edge
    task automatic do_tick();
        repeat (3) @(posedge clk);
        #1 scan_q = 1'b1;
        @(posedge clk);
        #1;
        if (ena) model_tick();
        else m_valid = 0;
        check("rows", 32'(rows), 32'(row_pat(m_row)));
        check("key_valid", 32'(kif.key_valid), 32'(m_valid));
        check("key_held", 32'(kif.key_held), 32'(m_held));
        check("key_code", 32'(kif.key_code), 32'(m_code));
        repeat (3) @(posedge clk);
        #1 scan_q = 1'b0;
        @(posedge clk);
        #1;
        check("strobe_count", 32'(n_strobes), 32'(m_strobes));
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    initial begin
        logic [3:0] seq [5];
        logic [3:0] rows_frozen;
        int         s0;
        int         exp_code;
        int         sel;

        seq = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD};
        m_strobes = 0;
        model_reset();

        #12;
        check("rst_rows", 32'(rows), 32'(4'b1110));
        check("rst_valid", 32'(kif.key_valid), 32'(0));
        check("rst_held", 32'(kif.key_held), 32'(0));
        check("rst_code", 32'(kif.key_code), 32'(0));
        rst = 1'b1;
        ena = 1'b1;

        // idle scan walks the rows one per tick
        for (int i = 0; i < 5; i++) begin
            do_tick();
            check("idle_rows", 32'(rows), 32'(seq[i]));
        end

        // clean press of row2/col1
        s0 = m_strobes;
        mask = 16'h1 << 9;
        ticks(6);
        check("press_code", 32'(kif.key_code), 32'(4'h9));
        check("press_held", 32'(kif.key_held), 32'(1));
        check("press_rows", 32'(rows), 32'(4'b1011));
        check("press_one_strobe", 32'(n_strobes), 32'(s0 + 1));

        // clean release
        mask = 16'h0;
        ticks(3);
        check("release_pending_held", 32'(kif.key_held), 32'(1));
        do_tick();
        check("release_held", 32'(kif.key_held), 32'(0));

        // re-press, then a 2-tick release glitch
        mask = 16'h1 << 9;
        ticks(8);
        s0 = m_strobes;
        mask = 16'h0;
        ticks(2);
        mask = 16'h1 << 9;
        ticks(2);
        check("glitch_held", 32'(kif.key_held), 32'(1));
        check("glitch_no_strobe", 32'(n_strobes), 32'(s0));
        mask = 16'h0;
        ticks(4);
        check("glitch_release", 32'(kif.key_held), 32'(0));

        // contact bounce on the current row
        s0 = m_strobes;
        for (int i = 0; i < 3; i++) begin
            mask = (i % 2 == 0) ? (16'h1 << (m_row*4 + 1)) : 16'h0;
            do_tick();
        end
        mask = 16'h0;
        ticks(2);
        check("bounce_no_strobe", 32'(n_strobes), 32'(s0));

        // two keys on row0: lowest column wins
        mask = 16'h0006;
        ticks(8);
        check("multi_code", 32'(kif.key_code), 32'(4'h1));
        mask = 16'h0;
        ticks(5);

        // disable mid-debounce for 20 ticks
        exp_code = m_row*4 + 3;
        mask = 16'h1 << exp_code;
        do_tick();
        s0 = m_strobes;
        rows_frozen = rows;
        ena = 1'b0;
        ticks(20);
        check("ena_rows_frozen", 32'(rows), 32'(rows_frozen));
        check("ena_no_strobe", 32'(n_strobes), 32'(s0));

        // raise ena while scan_q is already high: no tick may result
        @(posedge clk); #1 scan_q = 1'b1;
        repeat (2) @(posedge clk);
        #1 ena = 1'b1;
        repeat (3) @(posedge clk);
        #1 scan_q = 1'b0;
        check("reenable_no_tick", 32'(rows), 32'(rows_frozen));
        ticks(3);
        check("resume_strobe", 32'(n_strobes), 32'(s0 + 1));
        check("resume_code", 32'(kif.key_code), 32'(exp_code));

        // keep holding the key
        s0 = m_strobes;
        ticks(12);
`ifdef KEYPAD_SCAN_REPEAT_EN
        check("repeat_strobes", 32'(n_strobes), 32'(s0 + 2));
`else
        check("single_strobe", 32'(n_strobes), 32'(s0));
`endif

        // asynchronous reset while a key is held
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_rows", 32'(rows), 32'(4'b1110));
        check("arst_held", 32'(kif.key_held), 32'(0));
        check("arst_code", 32'(kif.key_code), 32'(0));
        check("arst_valid", 32'(kif.key_valid), 32'(0));
        model_reset();
        mask = 16'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        ticks(2);

        // randomized key activity checked against the model
        for (int it = 0; it < 400; it++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    mask = 16'h0;
                2, 3:    mask = 16'h1 << $urandom_range(0, 15);
                4:       mask = mask ^ (16'h1 << $urandom_range(0, 15));
                default: ;
            endcase
            if (ena && $urandom_range(0, 19) == 0) ena = 1'b0;
            else if (!ena && $urandom_range(0, 2) == 0) ena = 1'b1;
            do_tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
